// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared constants for the RV32M multiply/divide sequencer.
// Holds funct3 codes, FSM encodings and the shared-ALU mode/eval encodings.
// The ALU encodings must match the core's shared ALU instance.
package muldiv_seq_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  // RV32M funct3 codes handled by the sequencer
  localparam logic [2:0] MD_MUL  = 3'b000;
  localparam logic [2:0] MD_DIV  = 3'b100;
  localparam logic [2:0] MD_DIVU = 3'b101;
  localparam logic [2:0] MD_REM  = 3'b110;
  localparam logic [2:0] MD_REMU = 3'b111;

  // Sequencer state encodings
  localparam logic [2:0] MDS_IDLE  = 3'd0;
  localparam logic [2:0] MDS_NEG_A = 3'd1;
  localparam logic [2:0] MDS_NEG_B = 3'd2;
  localparam logic [2:0] MDS_ITER  = 3'd3;
  localparam logic [2:0] MDS_FIX   = 3'd4;
  localparam logic [2:0] MDS_DONE  = 3'd5;

  // Shared ALU controls
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [1:0] EVAL_EQ = 2'd0;
  localparam logic [1:0] EVAL_LT = 2'd1;

  // MULH/MULHSU/MULHU funct3 codes are reported through resp_illegal
  function automatic logic md_is_illegal(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M MUL/DIV/DIVU/REM/REMU using the core's shared ALU.
// Latency: 33 cycles MUL/DIVU/REMU, 36 cycles DIV/REM, 1 cycle for special cases.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready.
// Optional macro MULDIV_EARLY_OUT_EN: MUL finishes as soon as the multiplier is zero.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_illegal,
  output logic            alu_busy,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      alu_mode,
  output logic [1:0]      alu_eval_mode,
  output logic            alu_sign_ext,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_eval_out
);

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // r_a: multiplicand (MUL) or dividend/quotient (divide)
  // r_b: multiplier (MUL) or divisor (divide)
  // r_acc: product accumulator (MUL) or partial remainder (divide)
  logic [2:0]      r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic            r_sign_q;
  logic            r_sign_r;
  logic            r_illegal;

  logic            w_mul;
  logic            w_quot;
  logic            w_accept;
  logic [XLEN-1:0] w_rem_t;
  logic            w_qbit;
  logic [XLEN-1:0] w_a_nxt;
  logic [XLEN-1:0] w_b_nxt;
  logic [XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0] w_iter_res;
  logic [XLEN-1:0] w_fix_src;
  logic            w_fix_neg;

  assign w_mul    = (r_op == MD_MUL);
  assign w_quot   = (r_op == MD_DIV) || (r_op == MD_DIVU);
  assign w_accept = req_valid && (r_state == MDS_IDLE);

  assign req_ready     = (r_state == MDS_IDLE);
  assign resp_valid    = (r_state == MDS_DONE);
  assign resp_result   = r_res;
  assign resp_illegal  = r_illegal;
  assign alu_busy      = (r_state != MDS_IDLE) && (r_state != MDS_DONE);
  assign alu_sign_ext  = 1'b0;

  // Shared-ALU operand/mode selection; idle values when the ALU is not owned
  always_comb begin
    alu_in1       = '0;
    alu_in2       = '0;
    alu_mode      = ALU_ADD;
    alu_eval_mode = EVAL_EQ;
    case (r_state)
      MDS_NEG_A: begin
        alu_mode = ALU_SUB;
        alu_in2  = r_a;
      end
      MDS_NEG_B: begin
        alu_mode = ALU_SUB;
        alu_in2  = r_b;
      end
      MDS_ITER: begin
        if (w_mul) begin
          alu_mode = ALU_ADD;
          alu_in1  = r_acc;
          alu_in2  = r_a;
        end else begin
          alu_mode      = ALU_SUB;
          alu_eval_mode = EVAL_LT;
          alu_in1       = w_rem_t;
          alu_in2       = r_b;
        end
      end
      MDS_FIX: begin
        alu_mode = ALU_SUB;
        alu_in2  = w_fix_src;
      end
      default: ;
    endcase
  end

  // Next-iteration datapath values for shift-add multiply and restoring divide
  always_comb begin
    w_rem_t = {r_acc[XLEN-2:0], r_a[XLEN-1]};
    w_qbit  = ~alu_eval_out;
    if (w_mul) begin
      w_acc_nxt = r_b[0] ? alu_out : r_acc;
      w_a_nxt   = r_a << 1;
      w_b_nxt   = r_b >> 1;
    end else begin
      w_acc_nxt = w_qbit ? alu_out : w_rem_t;
      w_a_nxt   = {r_a[XLEN-2:0], w_qbit};
      w_b_nxt   = r_b;
    end
    w_iter_res = (w_mul || !w_quot) ? w_acc_nxt : w_a_nxt;
    w_fix_src  = w_quot ? r_a : r_acc;
    w_fix_neg  = (r_op == MD_DIV) ? r_sign_q : r_sign_r;
  end

  // Sequencer FSM and operand/result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= MDS_IDLE;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_res     <= '0;
      r_cnt     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        MDS_IDLE: begin
          if (w_accept) begin
            r_op      <= req_op;
            r_a       <= req_a;
            r_b       <= req_b;
            r_acc     <= '0;
            r_cnt     <= CNT_W'(XLEN);
            r_sign_q  <= req_a[XLEN-1] ^ req_b[XLEN-1];
            r_sign_r  <= req_a[XLEN-1];
            r_illegal <= 1'b0;
            if (md_is_illegal(req_op)) begin
              r_illegal <= 1'b1;
              r_res     <= '0;
              r_state   <= MDS_DONE;
            end else if ((req_op == MD_DIV || req_op == MD_DIVU) && req_b == '0) begin
              r_res   <= ALL_ONES;
              r_state <= MDS_DONE;
            end else if ((req_op == MD_REM || req_op == MD_REMU) && req_b == '0) begin
              r_res   <= req_a;
              r_state <= MDS_DONE;
            end else if (req_op == MD_DIV && req_a == INT_MIN && req_b == ALL_ONES) begin
              r_res   <= INT_MIN;
              r_state <= MDS_DONE;
            end else if (req_op == MD_REM && req_a == INT_MIN && req_b == ALL_ONES) begin
              r_res   <= '0;
              r_state <= MDS_DONE;
            end else if (req_op == MD_DIV || req_op == MD_REM) begin
              r_state <= MDS_NEG_A;
            end else begin
              r_state <= MDS_ITER;
            end
          end
        end
        MDS_NEG_A: begin
          if (r_a[XLEN-1]) r_a <= alu_out;
          r_state <= MDS_NEG_B;
        end
        MDS_NEG_B: begin
          if (r_b[XLEN-1]) r_b <= alu_out;
          r_state <= MDS_ITER;
        end
        MDS_ITER: begin
`ifdef MULDIV_EARLY_OUT_EN
          if (w_mul && r_b == '0) begin
            r_res   <= r_acc;
            r_state <= MDS_DONE;
          end else begin
`else
          begin
`endif
            r_a   <= w_a_nxt;
            r_b   <= w_b_nxt;
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              if (r_op == MD_DIV || r_op == MD_REM) begin
                r_state <= MDS_FIX;
              end else begin
                r_res   <= w_iter_res;
                r_state <= MDS_DONE;
              end
            end
          end
        end
        MDS_FIX: begin
          r_res   <= w_fix_neg ? alu_out : w_fix_src;
          r_state <= MDS_DONE;
        end
        MDS_DONE: begin
          if (resp_ready) r_state <= MDS_IDLE;
        end
        default: r_state <= MDS_IDLE;
      endcase
    end
  end

endmodule
